// File: rtl/uart_pkg.sv
// Shared UART constants and types used by the receive path.
package uart_pkg;

  localparam int FREQ            = 50_000_000;
  localparam int BAUD            = 9600;
  localparam int UART_BYTE_W     = 8;
  localparam int UART_FIFO_DEPTH = 16;

  typedef logic [UART_BYTE_W-1:0] uart_byte_t;

endpackage

// File: rtl/uart_fifo_mem.sv
// DEPTH x WIDTH register array: one synchronous write port, one asynchronous read port.
module uart_fifo_mem #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Storage is deliberately left unreset; the control logic gates stale data.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Show-ahead byte FIFO behind the UART receiver with sticky overrun flag.
// Optional drop counter port is built when UART_RX_FIFO_DROPCNT_EN is defined.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = UART_FIFO_DEPTH,
  parameter int WIDTH = UART_BYTE_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_valid,
  input  logic [WIDTH-1:0]       wr_data,
  output logic                   rd_valid,
  output logic [WIDTH-1:0]       rd_data,
  input  logic                   rd_ready,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overrun,
  input  logic                   overrun_clr
`ifdef UART_RX_FIFO_DROPCNT_EN
  ,
  output logic [7:0]             drop_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [WIDTH-1:0] mem_rdata;
  logic             push, pop, drop;

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign rd_valid = !empty;
  assign pop      = rd_valid && rd_ready;
  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign push     = wr_valid && (!full || pop);
  assign drop     = wr_valid && full && !pop;
  assign rd_data  = empty ? '0 : mem_rdata;

  uart_fifo_mem #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_mem (
    .clk  (clk),
    .we   (push),
    .waddr(wr_ptr),
    .wdata(wr_data),
    .raddr(rd_ptr),
    .rdata(mem_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Set has priority over clear so a drop is never lost to a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              overrun <= 1'b0;
    else if (drop)        overrun <= 1'b1;
    else if (overrun_clr) overrun <= 1'b0;
  end

`ifdef UART_RX_FIFO_DROPCNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 drop_cnt <= 8'd0;
    else if (drop)           drop_cnt <= overrun_clr ? 8'd1 :
                                         (drop_cnt == 8'hFF) ? drop_cnt : drop_cnt + 8'd1;
    else if (overrun_clr)    drop_cnt <= 8'd0;
  end
`else
  // No drop counter in this build; overrun alone records lost bytes.
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed scoreboard bench for uart_rx_fifo; honours UART_RX_FIFO_DROPCNT_EN.
module tb_uart_rx_fifo;

  localparam int DEPTH = 16;
  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             wr_valid = 1'b0;
  logic [WIDTH-1:0] wr_data = '0;
  logic             rd_valid;
  logic [WIDTH-1:0] rd_data;
  logic             rd_ready = 1'b0;
  logic             full, empty;
  logic [4:0]       count;
  logic             overrun;
  logic             overrun_clr = 1'b0;
`ifdef UART_RX_FIFO_DROPCNT_EN
  logic [7:0]       drop_cnt;
`endif

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] sb[$];
  int         m_count  = 0;
  logic       m_overrun = 1'b0;
  int         m_drop   = 0;

  uart_rx_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_valid   (wr_valid),
    .wr_data    (wr_data),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .rd_ready   (rd_ready),
    .full       (full),
    .empty      (empty),
    .count      (count),
    .overrun    (overrun),
    .overrun_clr(overrun_clr)
`ifdef UART_RX_FIFO_DROPCNT_EN
    ,
    .drop_cnt   (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One clock of stimulus; the model decides push/pop/drop independently of the DUT.
  task automatic applyStimulus(input logic wr, input logic [7:0] d, input logic rdy, input logic clr);
    logic pop_m, push_m, drop_m;
    logic [7:0] head;
    wr_valid    = wr;
    wr_data     = d;
    rd_ready    = rdy;
    overrun_clr = clr;
    pop_m  = rdy && (m_count != 0);
    push_m = wr && ((m_count < DEPTH) || pop_m);
    drop_m = wr && (m_count == DEPTH) && !pop_m;
    if (pop_m) begin
      head = sb.pop_front();
      checkOutput("rd_data_head", 32'(rd_data), 32'(head));
    end
    if (push_m) sb.push_back(d);
    if (push_m && !pop_m) m_count++;
    if (pop_m && !push_m) m_count--;
    if (drop_m) m_drop = clr ? 1 : ((m_drop == 255) ? 255 : m_drop + 1);
    else if (clr) m_drop = 0;
    if (drop_m) m_overrun = 1'b1;
    else if (clr) m_overrun = 1'b0;
    @(posedge clk);
    #1;
    wr_valid    = 1'b0;
    rd_ready    = 1'b0;
    overrun_clr = 1'b0;
    checkOutput("count", 32'(count), 32'(m_count));
    checkOutput("rd_valid", 32'(rd_valid), 32'(m_count != 0));
    checkOutput("overrun", 32'(overrun), 32'(m_overrun));
`ifdef UART_RX_FIFO_DROPCNT_EN
    checkOutput("drop_cnt", 32'(drop_cnt), 32'(m_drop));
`endif
  endtask

  task automatic modelReset();
    sb.delete();
    m_count   = 0;
    m_overrun = 1'b0;
    m_drop    = 0;
  endtask

  task automatic drain();
    while (m_count != 0) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("drain_empty", 32'(empty), 32'd1);
    checkOutput("drain_rd_data", 32'(rd_data), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] bench did not finish");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    modelReset();
    @(posedge clk);
    #1;
    checkOutput("rst_rd_valid", 32'(rd_valid), 32'd0);
    checkOutput("rst_rd_data", 32'(rd_data), 32'd0);
    checkOutput("rst_empty", 32'(empty), 32'd1);
    checkOutput("rst_full", 32'(full), 32'd0);
    checkOutput("rst_count", 32'(count), 32'd0);
    checkOutput("rst_overrun", 32'(overrun), 32'd0);

    // Three bytes held, then read out in order
    applyStimulus(1'b1, 8'h41, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h42, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h43, 1'b0, 1'b0);
    checkOutput("t1_count", 32'(count), 32'd3);
    checkOutput("t1_head", 32'(rd_data), 32'h41);
    drain();
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("ready_on_empty_count", 32'(count), 32'd0);

    // Fill to full, then drop one byte
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 8'(i), 1'b0, 1'b0);
    checkOutput("t2_full", 32'(full), 32'd1);
    checkOutput("t2_overrun_pre", 32'(overrun), 32'd0);
    applyStimulus(1'b1, 8'hAA, 1'b0, 1'b0);
    checkOutput("t2_count", 32'(count), 32'd16);
    checkOutput("t2_overrun", 32'(overrun), 32'd1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("t2_overrun_clr", 32'(overrun), 32'd0);

    // Write while full with a same-cycle read is accepted
    applyStimulus(1'b1, 8'h55, 1'b1, 1'b0);
    checkOutput("t3_count", 32'(count), 32'd16);
    checkOutput("t3_overrun", 32'(overrun), 32'd0);
    drain();

    // Interleaved traffic wraps the pointers several times
    for (int i = 0; i < 40; i++)
      applyStimulus(1'b1, 8'(i * 7 + 3), (m_count >= 2), 1'b0);
    checkOutput("t4_overrun", 32'(overrun), 32'd0);
    drain();

    // Drop with simultaneous clear keeps overrun set
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hEE, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hEF, 1'b0, 1'b1);
    checkOutput("t5_set_wins", 32'(overrun), 32'd1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("t5_cleared", 32'(overrun), 32'd0);

    // Asynchronous reset with five bytes stored
    for (int i = 0; i < 11; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("t6_pre_count", 32'(count), 32'd5);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("t6_async_empty", 32'(empty), 32'd1);
    checkOutput("t6_async_count", 32'(count), 32'd0);
    checkOutput("t6_async_rd_valid", 32'(rd_valid), 32'd0);
    modelReset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    applyStimulus(1'b1, 8'h5A, 1'b0, 1'b0);
    checkOutput("t6_after_head", 32'(rd_data), 32'h5A);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Byte buffer directly downstream of the UART receiver.
- Captures each received byte on a one-cycle write strobe.
- Holds up to DEPTH bytes and presents them to the consumer (command parser / bus bridge) through a show-ahead valid/ready read port.
- Flags overrun when a byte arrives while full.

Parameters:
- DEPTH, 16, number of byte entries; power of two, minimum 2.
- WIDTH, 8, data width in bits.

Ports:
- clk  input  1  system clock (50 MHz).
- rst  input  1  reset.
- wr_valid  input  1  one-cycle strobe from receiver: wr_data holds a new byte.
- wr_data  input  WIDTH  received byte.
- rd_valid  output  1  head entry available (= !empty).
- rd_data  output  WIDTH  head entry; 0 when rd_valid=0.
- rd_ready  input  1  consumer accepts head entry.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- count  output  $clog2(DEPTH)+1  current occupancy.
- overrun  output  1  sticky: a byte was dropped.
- overrun_clr  input  1  clears overrun.
- drop_cnt  output  8  only with UART_RX_FIFO_DROPCNT_EN.

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk. On reset, wr_ptr=0, rd_ptr=0, count=0, overrun=0, drop_cnt=0. Outputs: rd_valid=0, rd_data=0, empty=1, full=0.
- Memory contents are not reset.
- Reset mid-operation discards all stored bytes immediately.
- Pointers are $clog2(DEPTH) bits and wrap naturally at DEPTH-1 -> 0. Occupancy is tracked by the count register, not pointer compare.
- Pop condition: rd_valid && rd_ready. rd_ptr advances; the next head appears on rd_data in the following cycle.
- Push condition: wr_valid && (!full || pop).
  - Byte is written at mem[wr_ptr]; wr_ptr advances.
  - Push while full is accepted only if a pop occurs in the same cycle.
- Count update:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged.
  - neither: unchanged.
- Latency: a byte pushed at edge N is visible at rd_valid/rd_data after edge N (registered status), i.e. usable in cycle N+1.
- Empty FIFO: a write does not pass combinationally to rd_data in the same cycle (no fall-through).
- rd_ready while empty: ignored, no pointer or count change.
- Drop: wr_valid && full && !pop.
  - Byte is discarded; stored data is unchanged.
  - overrun=1 from the next cycle.
- Overrun clear: overrun_clr=1 clears overrun next cycle. If a drop and overrun_clr occur in the same cycle, the set wins (overrun stays 1).
- rd_data: combinational read of mem[rd_ptr], gated to 0 when empty.
- full and empty are derived from registered count; no glitch from inputs.

Optional Feature:
- Macro: UART_RX_FIFO_DROPCNT_EN.
- Defined:
  - drop_cnt port exists: 8-bit count of dropped bytes.
  - Increments on each drop and saturates at 255.
  - overrun_clr resets it to 0. A drop in the same cycle as clr yields drop_cnt=1.
- Undefined: drop_cnt port and its counter are absent; all other behaviour is identical.

Decomposition:
- Shared package uart_pkg holds:
  - FREQ (50_000_000) and default BAUD (9600).
  - UART_BYTE_W (8).
  - Typedef uart_byte_t (logic [7:0]).
  - Default FIFO depth constant UART_FIFO_DEPTH (16).
- Natural sub-module uart_fifo_mem: DEPTH x WIDTH register array with one synchronous write port and one asynchronous read port. Pointer/count/flag control stays in uart_rx_fifo.

Test Plan:
1. Reset, then write 0x41, 0x42, 0x43 on separate cycles with rd_ready=0 -> count=3; rd_valid=1; rd_data=0x41. Then assert rd_ready for 3 cycles -> 0x41, 0x42, 0x43 in order; empty=1; rd_data=0.
2. Write 16 bytes 0x00..0x0F, then 0xAA with no read -> full=1; count=16; overrun=1 next cycle; 0xAA absent on readout; drop_cnt=1 (if enabled).
3. Full FIFO with wr_valid=0x55 and rd_ready in the same cycle -> count stays 16; overrun stays 0; 0x55 is read last after 0x01..0x0F.
4. Write 40 bytes interleaved with reads, keeping count<=3 -> pointers wrap at least twice; data order is preserved; no overrun.
5. Set overrun; assert overrun_clr together with a new drop -> overrun=1. overrun_clr alone next cycle -> overrun=0; drop_cnt=0 (if enabled).
6. Assert rst asynchronously mid-stream with count=5 -> empty=1, count=0, rd_valid=0 immediately, before the next clk edge.
